// File: rtl/ntt_ctrl.sv
// ============================================================================
// Module  : ntt_ctrl
// Brief   : Address/strobe sequencer for a 256-point Kyber NTT/INTT butterfly
//           datapath, with PIPE-delayed write-back addressing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int BF_LAT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_inv,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_bf_mode,
    output logic       o_rd_en,
    output logic [7:0] o_rd_addr_a,
    output logic [7:0] o_rd_addr_b,
    output logic [6:0] o_tw_addr,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr_a,
    output logic [7:0] o_wr_addr_b
);

    localparam int PIPE = MEM_LAT + BF_LAT;
    localparam int CW   = $clog2(PIPE + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_inv;
    logic [2:0]      r_l;
    logic [6:0]      r_p;
    logic [CW-1:0]   r_cnt;

    logic            r_dl_en [PIPE];
    logic [7:0]      r_dl_a  [PIPE];
    logic [7:0]      r_dl_b  [PIPE];

    // Packs {addr_a, addr_b, tw} for pair p of layer l.
    function automatic logic [22:0] f_addr(input logic inv, input logic [2:0] l,
                                           input logic [6:0] p);
        logic [2:0] s;
        logic [7:0] len;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] j;
        logic [7:0] jb;
        logic [6:0] tw;
        s   = inv ? (l + 3'd1) : (3'd7 - l);
        len = 8'd1 << s;
        g   = {1'b0, p} >> s;
        r   = {1'b0, p} & (len - 8'd1);
        j   = ((g * len) << 1) + r;
        jb  = j + len;
        tw  = inv ? (7'(8'd128 >> l) - 7'd1 - g[6:0]) : (7'(8'd1 << l) + g[6:0]);
        return {j, jb, tw};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_inv       <= 1'b0;
            r_l         <= 3'd0;
            r_p         <= 7'd0;
            r_cnt       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_bf_mode   <= 2'b11;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= 8'd0;
            o_rd_addr_b <= 8'd0;
            o_tw_addr   <= 7'd0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_inv     <= i_inv;
                        r_l       <= 3'd0;
                        r_p       <= 7'd0;
                        r_state   <= S_ISSUE;
                        o_busy    <= 1'b1;
                        o_bf_mode <= {1'b0, i_inv};
                        o_rd_en   <= 1'b1;
                        {o_rd_addr_a, o_rd_addr_b, o_tw_addr} <= f_addr(i_inv, 3'd0, 7'd0);
                    end
                end
                S_ISSUE: begin
                    if (r_p == 7'd127) begin
                        r_state <= S_DRAIN;
                        r_p     <= 7'd0;
                        r_cnt   <= '0;
                        o_rd_en <= 1'b0;
                    end else begin
                        r_p <= r_p + 7'd1;
                        {o_rd_addr_a, o_rd_addr_b, o_tw_addr} <= f_addr(r_inv, r_l, r_p + 7'd1);
                    end
                end
                S_DRAIN: begin
                    // Hold off the next layer until the last write of this one retires.
                    if (r_cnt == CW'(PIPE - 1)) begin
                        if (r_l == 3'd6) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_l     <= r_l + 3'd1;
                            r_state <= S_ISSUE;
                            o_rd_en <= 1'b1;
                            {o_rd_addr_a, o_rd_addr_b, o_tw_addr} <= f_addr(r_inv, r_l + 3'd1, 7'd0);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    o_busy    <= 1'b0;
                    o_bf_mode <= 2'b11;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                r_dl_en[i] <= 1'b0;
                r_dl_a[i]  <= 8'd0;
                r_dl_b[i]  <= 8'd0;
            end
        end else begin
            r_dl_en[0] <= o_rd_en;
            r_dl_a[0]  <= o_rd_addr_a;
            r_dl_b[0]  <= o_rd_addr_b;
            for (int i = 1; i < PIPE; i++) begin
                r_dl_en[i] <= r_dl_en[i-1];
                r_dl_a[i]  <= r_dl_a[i-1];
                r_dl_b[i]  <= r_dl_b[i-1];
            end
        end
    end

    assign o_wr_en     = r_dl_en[PIPE-1];
    assign o_wr_addr_a = r_dl_a[PIPE-1];
    assign o_wr_addr_b = r_dl_b[PIPE-1];

endmodule

`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
// ============================================================================
// Module  : tb_ntt_ctrl
// Brief   : Self-checking bench for ntt_ctrl against a loop-based Kyber
//           schedule model, with vector table and reset/start corner cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ntt_ctrl;

    localparam int PIPE     = 5;
    localparam int LAYER    = 128 + PIPE;
    localparam int DONE_CYC = 7 * LAYER + 1;
    localparam int RUN_CYC  = DONE_CYC + 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_inv;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_bf_mode;
    logic       o_rd_en;
    logic [7:0] o_rd_addr_a;
    logic [7:0] o_rd_addr_b;
    logic [6:0] o_tw_addr;
    logic       o_wr_en;
    logic [7:0] o_wr_addr_a;
    logic [7:0] o_wr_addr_b;

    ntt_ctrl #(.MEM_LAT(1), .BF_LAT(4)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_inv(i_inv),
        .o_busy(o_busy), .o_done(o_done), .o_bf_mode(o_bf_mode),
        .o_rd_en(o_rd_en), .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b),
        .o_tw_addr(o_tw_addr), .o_wr_en(o_wr_en), .o_wr_addr_a(o_wr_addr_a),
        .o_wr_addr_b(o_wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic inv;
        int   l;
        int   p;
        int   a;
        int   b;
        int   tw;
    } vec_t;

    vec_t tbl[9];

    int n_vec = 0;
    int n_err = 0;

    int m_en [1024];
    int m_a  [1024];
    int m_b  [1024];
    int m_tw [1024];
    int cap_en [1024];
    int cap_a  [1024];
    int cap_b  [1024];
    int cap_tw [1024];
    int pend   [256];

    task automatic chk(input string nm, input int c, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 40) $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, c, act, exp);
        end
    endtask

    // Reference schedule built from the textbook Kyber loops (start/j/k form).
    task automatic build_model(input logic inv);
        int k, len, idx, c;
        for (int i = 0; i < 1024; i++) begin
            m_en[i] = 0; m_a[i] = 0; m_b[i] = 0; m_tw[i] = 0;
        end
        k = inv ? 127 : 1;
        for (int L = 0; L < 7; L++) begin
            len = inv ? (2 << L) : (128 >> L);
            idx = 0;
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    c = 1 + L * LAYER + idx;
                    m_en[c] = 1; m_a[c] = j; m_b[c] = j + len; m_tw[c] = k;
                    idx++;
                end
                k = inv ? k - 1 : k + 1;
            end
        end
    endtask

    task automatic run_xform(input logic inv, input logic glitch);
        int n_rd, n_wr, n_done;
        logic exp_busy;
        int exp_wr;
        build_model(inv);
        for (int i = 0; i < 256; i++) pend[i] = 0;
        n_rd = 0; n_wr = 0; n_done = 0;
        i_start = 1'b1;
        i_inv   = inv;
        for (int c = 1; c <= RUN_CYC; c++) begin
            @(negedge clk);
            exp_busy = (c <= DONE_CYC);
            exp_wr   = (c > PIPE) ? m_en[c-PIPE] : 0;
            cap_en[c] = int'(o_rd_en); cap_a[c] = int'(o_rd_addr_a);
            cap_b[c] = int'(o_rd_addr_b); cap_tw[c] = int'(o_tw_addr);
            chk("busy", c, int'(o_busy), int'(exp_busy));
            chk("done", c, int'(o_done), (c == DONE_CYC) ? 1 : 0);
            chk("bf_mode", c, int'(o_bf_mode), exp_busy ? int'(inv) : 3);
            chk("rd_en", c, int'(o_rd_en), m_en[c]);
            if (m_en[c] != 0) begin
                chk("rd_addr_a", c, int'(o_rd_addr_a), m_a[c]);
                chk("rd_addr_b", c, int'(o_rd_addr_b), m_b[c]);
                chk("tw_addr", c, int'(o_tw_addr), m_tw[c]);
            end
            chk("wr_en", c, int'(o_wr_en), exp_wr);
            if (exp_wr != 0) begin
                chk("wr_addr_a", c, int'(o_wr_addr_a), m_a[c-PIPE]);
                chk("wr_addr_b", c, int'(o_wr_addr_b), m_b[c-PIPE]);
            end
            if (o_rd_en) begin
                chk("raw_hazard_a", c, pend[o_rd_addr_a], 0);
                chk("raw_hazard_b", c, pend[o_rd_addr_b], 0);
                pend[o_rd_addr_a]++; pend[o_rd_addr_b]++;
                n_rd++;
            end
            if (o_wr_en) begin
                pend[o_wr_addr_a]--; pend[o_wr_addr_b]--;
                n_wr++;
            end
            if (o_done) n_done++;
            if (glitch) begin
                i_start = (c == DONE_CYC) ? 1'b1 :
                          (c < DONE_CYC) ? ($urandom_range(0, 15) == 0) : 1'b0;
                i_inv   = 1'($urandom);
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        chk("read_count", RUN_CYC, n_rd, 896);
        chk("write_count", RUN_CYC, n_wr, 896);
        chk("done_pulses", RUN_CYC, n_done, 1);
    endtask

    task automatic check_table(input logic inv);
        int c;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].inv == inv) begin
                c = 1 + tbl[i].l * LAYER + tbl[i].p;
                chk("tbl_rd_en", c, cap_en[c], 1);
                chk("tbl_a", c, cap_a[c], tbl[i].a);
                chk("tbl_b", c, cap_b[c], tbl[i].b);
                chk("tbl_tw", c, cap_tw[c], tbl[i].tw);
            end
        end
    endtask

    task automatic check_idle(input string nm, input int c);
        chk({nm, "_busy"}, c, int'(o_busy), 0);
        chk({nm, "_done"}, c, int'(o_done), 0);
        chk({nm, "_rd_en"}, c, int'(o_rd_en), 0);
        chk({nm, "_wr_en"}, c, int'(o_wr_en), 0);
        chk({nm, "_bf_mode"}, c, int'(o_bf_mode), 3);
    endtask

    initial begin
        tbl[0] = '{1'b0, 0, 0,   0, 128, 1};
        tbl[1] = '{1'b0, 0, 127, 127, 255, 1};
        tbl[2] = '{1'b0, 1, 0,   0, 64, 2};
        tbl[3] = '{1'b0, 1, 64,  128, 192, 3};
        tbl[4] = '{1'b0, 6, 2,   4, 6, 65};
        tbl[5] = '{1'b1, 0, 0,   0, 2, 127};
        tbl[6] = '{1'b1, 0, 1,   1, 3, 127};
        tbl[7] = '{1'b1, 0, 2,   4, 6, 126};
        tbl[8] = '{1'b1, 6, 0,   0, 128, 1};

        rst = 1'b1; i_start = 1'b0; i_inv = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset", 0);
        chk("reset_rd_addr_a", 0, int'(o_rd_addr_a), 0);
        chk("reset_rd_addr_b", 0, int'(o_rd_addr_b), 0);
        chk("reset_tw_addr", 0, int'(o_tw_addr), 0);
        chk("reset_wr_addr_a", 0, int'(o_wr_addr_a), 0);
        chk("reset_wr_addr_b", 0, int'(o_wr_addr_b), 0);
        rst = 1'b0;
        @(negedge clk);

        run_xform(1'b0, 1'b0);
        check_table(1'b0);
        for (int c = 129; c <= 133; c++) chk("drain_gap", c, cap_en[c], 0);
        chk("layer1_start", 134, cap_en[134], 1);

        run_xform(1'b1, 1'b0);
        check_table(1'b1);

        run_xform(1'($urandom), 1'b1);
        run_xform(1'($urandom), 1'b1);

        // Reset in the middle of a forward transform.
        i_start = 1'b1; i_inv = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            i_start = (c == 50) ? 1'b1 : 1'b0;
        end
        chk("pre_rst_busy", 300, int'(o_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst", 301);
        rst = 1'b0;
        for (int c = 302; c < 312; c++) begin
            @(negedge clk);
            check_idle("post_rst", c);
        end

        run_xform(1'b0, 1'b0);
        check_table(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
